// File: rtl/assoc_two_level_cache.sv
// Read-only two-level (L1 + L2) set-associative cache in front of a combinational
// backing memory whose word at address A is A. Single-cycle access with a registered result.
module assoc_two_level_cache #(
  parameter int WAYS       = 1,
  parameter int LINE_WORDS = 4,
  parameter int L1_LINES   = 16,
  parameter int L2_LINES   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  input  logic        read,
  output logic [31:0] read_data,
  output logic        l1_hit,
  output logic        l2_hit
);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int AW      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int L1_SETS = L1_LINES / WAYS;
  localparam int L2_SETS = L2_LINES / WAYS;
  localparam int L1_IW   = $clog2(L1_SETS);
  localparam int L2_IW   = $clog2(L2_SETS);
  localparam int L1_TW   = 11 - OFF_W - L1_IW;
  localparam int L2_TW   = 11 - OFF_W - L2_IW;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;
  typedef logic [WAYS-1:0][AW-1:0]     age_t;

  // Age 0 is MRU, WAYS-1 is LRU; ages within a set always form a permutation.
  function automatic age_t age_init();
    age_t r;
    for (int w = 0; w < WAYS; w++) r[w] = AW'(WAYS - 1 - w);
    return r;
  endfunction

  function automatic age_t touch(input age_t age, input logic [AW-1:0] way);
    age_t r;
    r = age;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == way) r[w] = '0;
      else if (age[w] < age[way]) r[w] = age[w] + AW'(1);
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] pick_victim(input logic [WAYS-1:0] vld, input age_t age);
    logic [AW-1:0] v;
    logic          found;
    v     = '0;
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vld[w] && !found) begin
        v     = AW'(w);
        found = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) if (age[w] == AW'(WAYS - 1)) v = AW'(w);
    end
    return v;
  endfunction

  logic [WAYS-1:0]  l1_val_q [L1_SETS];
  age_t             l1_age_q [L1_SETS];
  logic [L1_TW-1:0] l1_tag_q [L1_SETS][WAYS];
  line_t            l1_dat_q [L1_SETS][WAYS];
  logic [WAYS-1:0]  l2_val_q [L2_SETS];
  age_t             l2_age_q [L2_SETS];
  logic [L2_TW-1:0] l2_tag_q [L2_SETS][WAYS];
  line_t            l2_dat_q [L2_SETS][WAYS];

  logic [OFF_W-1:0] off;
  logic [L1_IW-1:0] i1;
  logic [L1_TW-1:0] t1;
  logic [L2_IW-1:0] i2;
  logic [L2_TW-1:0] t2;
  logic             h1_c, h2_c;
  logic [AW-1:0]    hw1, hw2, vw1, vw2, tw1, tw2;
  line_t            mem_line, fill_line;
  logic [31:0]      word_c;

  assign off = addr[OFF_W-1:0];
  assign i1  = addr[OFF_W +: L1_IW];
  assign t1  = addr[10 -: L1_TW];
  assign i2  = addr[OFF_W +: L2_IW];
  assign t2  = addr[10 -: L2_TW];

  always_comb begin
    h1_c = 1'b0;
    hw1  = '0;
    h2_c = 1'b0;
    hw2  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (l1_val_q[i1][w] && l1_tag_q[i1][w] == t1) begin
        h1_c = 1'b1;
        hw1  = AW'(w);
      end
      if (l2_val_q[i2][w] && l2_tag_q[i2][w] == t2) begin
        h2_c = 1'b1;
        hw2  = AW'(w);
      end
    end
    vw1 = pick_victim(l1_val_q[i1], l1_age_q[i1]);
    vw2 = pick_victim(l2_val_q[i2], l2_age_q[i2]);
    tw1 = h1_c ? hw1 : vw1;
    tw2 = h2_c ? hw2 : vw2;
    for (int w = 0; w < LINE_WORDS; w++)
      mem_line[w] = {{(32 - 11){1'b0}}, addr[10:OFF_W], OFF_W'(w)};
    fill_line = h2_c ? l2_dat_q[i2][hw2] : mem_line;
    word_c    = h1_c ? l1_dat_q[i1][hw1][off] : fill_line[off];
  end

  // Control state: valid bits, LRU ages and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < L1_SETS; s++) begin
        l1_val_q[s] <= '0;
        l1_age_q[s] <= age_init();
      end
      for (int s = 0; s < L2_SETS; s++) begin
        l2_val_q[s] <= '0;
        l2_age_q[s] <= age_init();
      end
      read_data <= '0;
      l1_hit    <= 1'b0;
      l2_hit    <= 1'b0;
    end else if (read) begin
      l1_hit       <= h1_c;
      l2_hit       <= !h1_c && h2_c;
      read_data    <= word_c;
      l1_age_q[i1] <= touch(l1_age_q[i1], tw1);
      if (!h1_c) begin
        l1_val_q[i1][vw1] <= 1'b1;
        l2_age_q[i2]      <= touch(l2_age_q[i2], tw2);
        if (!h2_c) l2_val_q[i2][vw2] <= 1'b1;
      end
    end else begin
      l1_hit <= 1'b0;
      l2_hit <= 1'b0;
    end
  end

  // Tags and line data carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (read && !rst && !h1_c) begin
      l1_tag_q[i1][vw1] <= t1;
      l1_dat_q[i1][vw1] <= fill_line;
      if (!h2_c) begin
        l2_tag_q[i2][vw2] <= t2;
        l2_dat_q[i2][vw2] <= mem_line;
      end
    end
  end
endmodule

// File: tb/tb_assoc_two_level_cache.sv
// Scoreboard bench driving WAYS=1, 2 and 4 instances with one stimulus stream,
// predicting each with an ordered-list LRU reference model.
module tb_assoc_two_level_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic [10:0] addr = '0;
  logic [31:0] rd [3];
  logic        h1 [3];
  logic        h2 [3];

  always #5 clk = ~clk;

  assoc_two_level_cache #(.WAYS(1)) u_w1 (.clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(rd[0]), .l1_hit(h1[0]), .l2_hit(h2[0]));
  assoc_two_level_cache #(.WAYS(2)) u_w2 (.clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(rd[1]), .l1_hit(h1[1]), .l2_hit(h2[1]));
  assoc_two_level_cache #(.WAYS(4)) u_w4 (.clk(clk), .rst(rst), .addr(addr), .read(read),
    .read_data(rd[2]), .l1_hit(h1[2]), .l2_hit(h2[2]));

  localparam int WV [3] = '{1, 2, 4};

  int          n_vec = 0;
  int          n_err = 0;
  int          l1m [3][64][$];
  int          l2m [3][64][$];
  logic [33:0] last [3];
  logic [33:0] sbq [3][$];

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got l1=%b l2=%b data=%h, want l1=%b l2=%b data=%h",
               tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Front of each list is MRU; a miss in a full set drops the back entry.
  function automatic bit lookup(int k, bit lvl2, int s, int ln);
    int q[$];
    bit hit;
    if (lvl2) q = l2m[k][s];
    else      q = l1m[k][s];
    hit = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == ln) begin
        q.delete(i);
        hit = 1'b1;
        break;
      end
    end
    if (!hit && q.size() == WV[k]) q.pop_back();
    q.push_front(ln);
    if (lvl2) l2m[k][s] = q;
    else      l1m[k][s] = q;
    return hit;
  endfunction

  function automatic logic [33:0] model(int k, bit r, bit rdq, logic [10:0] a);
    int ln;
    bit x1, x2;
    if (r) begin
      for (int s = 0; s < 64; s++) begin
        l1m[k][s].delete();
        l2m[k][s].delete();
      end
      last[k] = '0;
    end else if (rdq) begin
      ln = int'(a) >> 2;
      x1 = lookup(k, 1'b0, ln % (16 / WV[k]), ln);
      x2 = 1'b0;
      if (!x1) x2 = lookup(k, 1'b1, ln % (64 / WV[k]), ln);
      last[k] = {x1, x2, 21'b0, a};
    end else begin
      last[k][33:32] = 2'b00;
    end
    return last[k];
  endfunction

  task automatic step(input bit r, input bit rdq, input logic [10:0] a);
    logic [33:0] e;
    @(negedge clk);
    rst  = r;
    read = rdq;
    addr = a;
    for (int k = 0; k < 3; k++) sbq[k].push_back(model(k, r, rdq, a));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sbq[k].pop_front();
      chk($sformatf("W%0d_v%0d_a%03h", WV[k], n_vec / 3, a), {h1[k], h2[k], rd[k]}, e);
    end
  endtask

  task automatic rd_seq(input logic [10:0] a);
    step(1'b0, 1'b1, a);
  endtask

  initial begin
    logic [10:0] ra;
    step(1'b1, 1'b0, 11'h000);
    step(1'b1, 1'b1, 11'h020);
    // first-fill, L1 hit, other line, same line other offset
    rd_seq(11'h020); rd_seq(11'h020); rd_seq(11'h040); rd_seq(11'h023);
    // conflict pair on the direct-mapped L1 set
    step(1'b1, 1'b0, 11'h000);
    rd_seq(11'h020); rd_seq(11'h060); rd_seq(11'h020);
    // five lines into one 4-way set, then LRU victim returns from L2
    step(1'b1, 1'b0, 11'h000);
    rd_seq(11'h000); rd_seq(11'h010); rd_seq(11'h020); rd_seq(11'h030);
    rd_seq(11'h040); rd_seq(11'h000); rd_seq(11'h040);
    // reset drops the concurrent access and forgets the fill
    rd_seq(11'h020);
    step(1'b1, 1'b1, 11'h020);
    rd_seq(11'h020);
    // idle cycles hold data, clear flags, keep contents
    rd_seq(11'h020);
    step(1'b0, 1'b0, 11'h7ff); step(1'b0, 1'b0, 11'h123); step(1'b0, 1'b0, 11'h000);
    rd_seq(11'h020);
    // mixed traffic on a small line pool to force hits, conflicts and evictions
    for (int i = 0; i < 400; i++) begin
      ra = {2'(($urandom_range(0, 7) * 4 + $urandom_range(0, 1)) >> 4) * 2'b00,
            7'(($urandom_range(0, 7) * 4 + $urandom_range(0, 1))), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 99) == 0)      step(1'b1, 1'($urandom_range(0, 1)), ra);
      else if ($urandom_range(0, 5) == 0)  step(1'b0, 1'b0, ra);
      else                                 rd_seq(ra);
    end
    for (int i = 0; i < 100; i++) rd_seq(11'($urandom_range(0, 2047)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/assoc_two_level_cache.md
Name: assoc_two_level_cache

Overview:
- Read-only, two-level (L1 + L2) cache in front of a deterministic 2048-word backing memory.
- One parameterized block covers the direct-mapped, 2-way and 4-way system variants through the WAYS parameter.
- Sits between a requester issuing single-word reads and the memory model.
- Reports per access whether data came from L1, from L2, or from memory.

Parameters:
- WAYS, 1, associativity of both L1 and L2; legal values 1, 2, 4.
- LINE_WORDS, 4, 32-bit words per cache line; fixed at 4.
- L1_LINES, 16, total L1 lines; L1 sets = L1_LINES/WAYS.
- L2_LINES, 64, total L2 lines; L2 sets = L2_LINES/WAYS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- addr  input  11  word address of the read.
- read  input  1  read request, sampled on the rising edge.
- read_data  output  32  data word of the last completed read.
- l1_hit  output  1  last completed read hit in L1.
- l2_hit  output  1  last completed read missed L1 and hit L2.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Backing memory: combinational. Word at address A = {21'b0, A}. No writes exist. No dirty state.
- Address split: offset = addr[1:0].
  - L1 index = next log2(L1 sets) bits; L1 tag = remaining upper bits.
  - L2 index and tag are split the same way using L2 sets.
- Storage:
  - Each line holds valid, tag and 4x32-bit data.
  - Each set holds LRU state (1 bit for 2-way; age counters or ordered list for 4-way; none for WAYS=1).
- Reset (rst=1 at a rising edge):
  - Clears all valid bits in both levels and resets LRU state so way 0 is the first victim.
  - read_data=0, l1_hit=0, l2_hit=0.
  - rst overrides read; an access presented during reset is dropped.
- Access: read=1 at a rising edge performs the full access in that edge. Outputs are registered and valid from that edge until the next edge (1-cycle latency, no stall, no busy). A new access may be issued every cycle.
  - L1 hit: l1_hit=1, l2_hit=0, read_data = L1 word[offset]. Update L1 LRU (hit way becomes MRU).
  - L1 miss, L2 hit: l1_hit=0, l2_hit=1, read_data = L2 word.
    - Copy the line into L1 victim way: first invalid way (lowest index), else LRU way.
    - Update L1 LRU and L2 LRU.
  - Miss in both: l1_hit=0, l2_hit=0, read_data = memory word.
    - Fill the full line (4 words, line-aligned) into L2 victim and L1 victim.
    - Both filled ways become MRU.
  - L1 evictions are silent; L2 evictions do not back-invalidate L1 (non-inclusive is acceptable).
  - l1_hit and l2_hit are never both 1.
- Idle: read=0 at a rising edge sets l1_hit=0 and l2_hit=0. read_data holds. Cache state is unchanged.
- Repeated read of the same addr held over consecutive cycles: first edge is the miss and fill; second edge is an L1 hit.
- Victim choice and hit detection are identical for every WAYS value except set count and associativity; WAYS=1 has no LRU.

Test Plan:
- Reset, then addr=0x020 with read=1 for two edges: first result l1_hit=0, l2_hit=0, read_data=0x20; second result l1_hit=1, read_data=0x20. Then addr=0x040: l1_hit=0, l2_hit=0, read_data=0x40 (all WAYS).
- After 0x020 is filled, read 0x023: l1_hit=1, read_data=0x23 (same line, different offset).
- Sequence 0x020, 0x060, 0x020: WAYS=1 gives the third access l1_hit=0, l2_hit=1, read_data=0x20. WAYS=2 and WAYS=4 give the third access l1_hit=1.
- WAYS=4: read 0x000, 0x010, 0x020, 0x030, 0x040, then 0x000. The last access gives l1_hit=0, l2_hit=1 (LRU evicted 0x000). A following read of 0x040 gives l1_hit=1.
- Fill 0x020, assert rst for one edge, then read 0x020: l1_hit=0, l2_hit=0. Both flags read 0 during and immediately after reset.
- read=0 for several cycles after a hit: l1_hit and l2_hit are 0, read_data is unchanged. A subsequent read of the same address is still an L1 hit.
